// File: rtl/ex_flag_stage.sv
// ============================================================================
// Module   : ex_flag_stage
// Brief    : EX/MEM pipeline register with architectural Z/V/N flags and HLT.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ex_flag_stage #(
  parameter int DATA_W = 16,
  parameter int REG_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              flush,
  input  logic              valid_in,
  input  logic [3:0]        opcode_in,
  input  logic [DATA_W-1:0] result_in,
  input  logic              ovfl_in,
  input  logic [DATA_W-1:0] sdata_in,
  input  logic [REG_W-1:0]  rd_in,
  input  logic              regwr_in,
  input  logic              memrd_in,
  input  logic              memwr_in,
  output logic              valid_out,
  output logic [DATA_W-1:0] result_out,
  output logic [DATA_W-1:0] sdata_out,
  output logic [REG_W-1:0]  rd_out,
  output logic              regwr_out,
  output logic              memrd_out,
  output logic              memwr_out,
  output logic              flag_z,
  output logic              flag_v,
  output logic              flag_n,
  output logic              halted
);

  localparam logic [3:0] c_op_add = 4'b0000;
  localparam logic [3:0] c_op_sub = 4'b0001;
  localparam logic [3:0] c_op_xor = 4'b0010;
  localparam logic [3:0] c_op_sll = 4'b0100;
  localparam logic [3:0] c_op_sra = 4'b0101;
  localparam logic [3:0] c_op_ror = 4'b0110;
  localparam logic [3:0] c_op_hlt = 4'b1111;

  logic              r_valid;
  logic [DATA_W-1:0] r_result;
  logic [DATA_W-1:0] r_sdata;
  logic [REG_W-1:0]  r_rd;
  logic              r_regwr;
  logic              r_memrd;
  logic              r_memwr;
  logic              r_z;
  logic              r_v;
  logic              r_n;
  logic              r_halted;

  logic w_live;
  logic w_z_nxt;
  logic w_v_nxt;
  logic w_n_nxt;

  // Once halted, everything arriving from EX is demoted to a bubble.
  assign w_live = valid_in & ~r_halted;

  always_comb begin
    w_z_nxt = r_z;
    w_v_nxt = r_v;
    w_n_nxt = r_n;
    if (w_live) begin
      case (opcode_in)
        c_op_add, c_op_sub: begin
          w_z_nxt = (result_in == '0);
          w_v_nxt = ovfl_in;
          w_n_nxt = result_in[DATA_W-1];
        end
        c_op_xor, c_op_sll, c_op_sra, c_op_ror: begin
          w_z_nxt = (result_in == '0);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid  <= 1'b0;
      r_result <= '0;
      r_sdata  <= '0;
      r_rd     <= '0;
      r_regwr  <= 1'b0;
      r_memrd  <= 1'b0;
      r_memwr  <= 1'b0;
      r_z      <= 1'b0;
      r_v      <= 1'b0;
      r_n      <= 1'b0;
      r_halted <= 1'b0;
    end else if (!stall) begin
      if (flush) begin
        r_valid  <= 1'b0;
        r_result <= '0;
        r_sdata  <= '0;
        r_rd     <= '0;
        r_regwr  <= 1'b0;
        r_memrd  <= 1'b0;
        r_memwr  <= 1'b0;
      end else begin
        r_valid  <= w_live;
        r_result <= result_in;
        r_sdata  <= sdata_in;
        r_rd     <= rd_in;
        r_regwr  <= w_live & regwr_in;
        r_memrd  <= w_live & memrd_in;
        r_memwr  <= w_live & memwr_in;
        r_z      <= w_z_nxt;
        r_v      <= w_v_nxt;
        r_n      <= w_n_nxt;
        if (valid_in && (opcode_in == c_op_hlt)) begin
          r_halted <= 1'b1;
        end
      end
    end
  end

  assign valid_out  = r_valid;
  assign result_out = r_result;
  assign sdata_out  = r_sdata;
  assign rd_out     = r_rd;
  assign regwr_out  = r_regwr;
  assign memrd_out  = r_memrd;
  assign memwr_out  = r_memwr;
  assign flag_z     = r_z;
  assign flag_v     = r_v;
  assign flag_n     = r_n;
  assign halted     = r_halted;

endmodule

`default_nettype wire
